// File: rtl/key_pkg.sv
// Shared definitions for the key input chain: FSM state encoding, default clock
// frequency and millisecond-to-cycle conversion used by debounce and click stages.
package key_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        EMIT    = ST_EMIT,
        HOLD    = ST_HOLD
    } state_t;

    localparam int unsigned CLK_FREQ = 50_000_000;

    function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                                 input int unsigned clk_freq = CLK_FREQ);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/key_click_decoder_if.sv
// Press-pulse input and click-event outputs of the click decoder.
interface key_click_decoder_if #(
    parameter int MAX_CLICKS = 3
);
    localparam int CNT_W = $clog2(MAX_CLICKS + 1);

    logic             key_come;
    logic             click_valid;
    logic [CNT_W-1:0] click_num;
    logic             busy;

    modport master (output key_come, input click_valid, click_num, busy);
    modport slave  (input key_come, output click_valid, click_num, busy);

endinterface

// File: rtl/key_click_timer.sv
// Clearable up-counter with a runtime terminal count; wraps to zero on the
// cycle it flags expiry so it never overflows its width.
module key_click_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc,
    output logic         expire
);

    logic [W-1:0] count;

    assign expire = en && (count == tc);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= expire ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced key presses into single/double/.../N-click events.
// Optional post-event holdoff is compiled in with `define KEY_CLICK_HOLDOFF_EN.
module key_click_decoder
    import key_pkg::*;
#(
    parameter int WINDOW_CYC  = int'(ms_to_cycles(500)),
    parameter int MAX_CLICKS  = 3,
    parameter int HOLDOFF_CYC = int'(ms_to_cycles(100))
) (
    input logic               clk,
    input logic               rst,
    key_click_decoder_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_CLICKS + 1);
    localparam int WIN_W = $clog2(WINDOW_CYC);
`ifdef KEY_CLICK_HOLDOFF_EN
    localparam int HOLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam int TW     = (WIN_W > HOLD_W) ? WIN_W : HOLD_W;
`else
    localparam int TW     = WIN_W;
`endif

    if (WINDOW_CYC < 2 || MAX_CLICKS < 1 || HOLDOFF_CYC < 1) begin : g_param_check
        $error("key_click_decoder: WINDOW_CYC >= 2, MAX_CLICKS >= 1, HOLDOFF_CYC >= 1 required");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             click_valid_r;
    logic [CNT_W-1:0] click_num_r;
    logic             busy_r;

    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_expire;
    logic [TW-1:0]    tmr_tc;

    // One timer serves both the inter-click window and the holdoff period.
    always_comb begin
        tmr_en  = (state == COLLECT);
        tmr_tc  = TW'(WINDOW_CYC - 1);
`ifdef KEY_CLICK_HOLDOFF_EN
        if (state == HOLD) begin
            tmr_en = 1'b1;
            tmr_tc = TW'(HOLDOFF_CYC - 1);
        end
`endif
        tmr_clr = !tmr_en || ((state == COLLECT) && bus.key_come);
    end

    key_click_timer #(
        .W (TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .tc     (tmr_tc),
        .expire (tmr_expire)
    );

    // Outputs follow the state one edge later, so the pulse lines up with busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            click_valid_r <= 1'b0;
            click_num_r   <= '0;
            busy_r        <= 1'b0;
        end else begin
            click_valid_r <= (state == EMIT);
            busy_r        <= (state != IDLE);
            if (state == EMIT) begin
                click_num_r <= cnt;
            end

            case (state)
                IDLE: begin
                    if (bus.key_come) begin
                        cnt   <= CNT_W'(1);
                        state <= (MAX_CLICKS == 1) ? EMIT : COLLECT;
                    end
                end
                COLLECT: begin
                    // A full group closes on the following edge; a press landing on
                    // the expiry cycle still counts and reopens the window.
                    if (cnt == CNT_W'(MAX_CLICKS)) begin
                        state <= EMIT;
                    end else if (bus.key_come) begin
                        cnt <= cnt + 1'b1;
                    end else if (tmr_expire) begin
                        state <= EMIT;
                    end
                end
                EMIT: begin
`ifdef KEY_CLICK_HOLDOFF_EN
                    state <= HOLD;
`else
                    state <= IDLE;
`endif
                end
`ifdef KEY_CLICK_HOLDOFF_EN
                HOLD: begin
                    if (tmr_expire) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.click_valid = click_valid_r;
    assign bus.click_num   = click_num_r;
    assign bus.busy        = busy_r;

endmodule

// File: doc/key_click_decoder.md
Name: key_click_decoder

Overview:
- Sits directly downstream of the key debounce/edge stage; consumes its one-cycle debounced press pulse (key_come).
- Groups presses that arrive within a configurable inter-click window into one event.
- Reports single/double/…/N-click events as a one-cycle valid pulse plus the click count, for the application control logic.

Parameters:
- WINDOW_CYC, 25_000_000, max clk cycles allowed between consecutive presses of one group (500 ms at 50 MHz); must be >= 2.
- MAX_CLICKS, 3, click count at which the group closes immediately; must be >= 1.
- HOLDOFF_CYC, 5_000_000, cycles key_come is ignored after an event (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- key_come  input  1  one-cycle debounced press pulse from the edge stage.
- click_valid  output  1  one-cycle pulse: a click group has closed.
- click_num  output  CNT_W  clicks in the closed group, 1..MAX_CLICKS; CNT_W = $clog2(MAX_CLICKS+1).
- busy  output  1  high while a group is open (or in holdoff).

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset state:
  - state = IDLE; click_valid = 0; click_num = 0; busy = 0; internal count and timer = 0.
  - rst asserted mid-group discards the group; no event is emitted.
- States: IDLE, COLLECT, EMIT; plus HOLD when the optional feature is enabled.
- IDLE:
  - key_come = 1 -> COLLECT, with cnt = 1 and timer = 0.
  - If MAX_CLICKS = 1, go straight to EMIT instead.
- COLLECT:
  - Timer increments each cycle.
  - key_come = 1 -> cnt + 1, timer cleared.
  - If the new cnt = MAX_CLICKS -> EMIT next cycle.
  - key_come = 0 and timer = WINDOW_CYC-1 -> EMIT.
- Simultaneous events: key_come in the same cycle as timer expiry counts as a click. The group stays open, unless that click reaches MAX_CLICKS.
- EMIT (exactly one cycle):
  - click_valid = 1 and click_num = cnt, both registered outputs.
  - Then -> IDLE (or HOLD).
- Latency:
  - click_valid rises WINDOW_CYC+1 clock edges after the edge that sampled the last accepted key_come.
  - When the MAX_CLICKS-th press closes the group, latency is 2 edges.
- key_come during EMIT is dropped. Required; verify it.
- click_num holds its value until the next EMIT. It is only meaningful when click_valid = 1.
- busy = 1 in COLLECT, EMIT and HOLD; 0 in IDLE.
- Counter widths:
  - cnt never exceeds MAX_CLICKS, so no wrap-around.
  - Timer is $clog2(WINDOW_CYC) bits and cannot overflow, because it clears at expiry.

Optional Feature:
- Macro: KEY_CLICK_HOLDOFF_EN.
- Defined:
  - After EMIT, enter HOLD for HOLDOFF_CYC cycles using the same timer, ignoring key_come, then return to IDLE.
  - rst in HOLD -> IDLE.
  - A key_come on the last HOLD cycle is ignored.
- Undefined: EMIT -> IDLE directly. HOLD state, HOLDOFF_CYC logic and the related timer width are not compiled.

Decomposition:
- Shared package/include key_pkg:
  - state encoding localparams (IDLE = 2'd0, COLLECT = 2'd1, EMIT = 2'd2, HOLD = 2'd3);
  - default clock frequency constant CLK_FREQ = 50_000_000;
  - ms-to-cycles constant helpers, shared with the debounce stage.
- One natural sub-module: key_click_timer.
  - Clearable up-counter; width parameter; terminal-count input; one-cycle expire flag output.
  - Used for both the window and the holdoff.

Test Plan (bench overrides WINDOW_CYC = 100, MAX_CLICKS = 3, HOLDOFF_CYC = 50; clk period 20 ns):
- Single press: one key_come pulse at edge T -> click_valid = 1 at edge T+101 with click_num = 1, exactly one cycle; busy high from T+1 to T+101.
- Double press: pulses at T and T+60 -> one click_valid at T+161 with click_num = 2; no event at T+101.
- Max clicks: pulses at T, T+10, T+20 -> click_valid at T+22 with click_num = 3. A fourth pulse at T+22 (EMIT) is dropped; a pulse at T+30 starts a new group, valid at T+131 with click_num = 1.
- Window boundary: pulse at T, second pulse exactly on the expiry cycle T+100 -> counted, single event at T+201 with click_num = 2. Second pulse at T+102 -> two events, each click_num = 1.
- Reset mid-group: pulses at T, T+30; rst high at T+50 for 1 cycle -> no click_valid for 200 cycles; outputs 0; busy 0 the cycle after reset.
- With KEY_CLICK_HOLDOFF_EN: event at E; pulse at E+20 ignored (no busy-drop, no event); pulse at E+60 -> event with click_num = 1 at E+161.
